// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states and control-register field encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    localparam logic DS_8BIT   = 1'b1;  // cr_ds: 1 = 8 data bits, 0 = 7
    localparam logic STOP_2BIT = 1'b1;  // cr_s: 1 = two stop bits, 0 = one

    // Divider values 0 and 1 cannot place a sample mid-bit, so they run as 2.
    function automatic logic [15:0] eff_clk_div(input logic [15:0] div);
        return (div < 16'd2) ? 16'd2 : div;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchroniser for an asynchronous level input; resets to 1 (idle line).
module synchronizer #(
    parameter int STAGES = 2    // at least 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff;

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ff <= '1;
        else       ff <= {ff[STAGES-2:0], d_i};
    end

    assign q_o = ff[STAGES-1];

endmodule

// File: rtl/rx_frontend.sv
// UART receive frontend: start-edge detect, mid-bit sampling, parity/stop checking.
module rx_frontend
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] cr_clk_div_i,
    input  logic        cr_ds_i,
    input  logic [1:0]  cr_p_i,
    input  logic        cr_s_i,
    input  logic        uart_rx_i,
    output logic [7:0]  dr_o,
    output logic        valid_o,
    output logic        frame_error_o,
    output logic        parity_error_o
);

    rx_state_t   state, state_n;
    logic        rx_sync, rx_d, fall;
    logic [15:0] baud_cnt, baud_n;
    logic [3:0]  bit_cnt, bit_n;
    logic        stop_left, stop_left_n;
    logic        ferr, ferr_n, perr, perr_n;
    logic        latch_cfg, shift_en, out_en, tick;
    logic [15:0] div_q;
    logic        ds_q;
    logic [1:0]  par_q;
    logic [7:0]  sr, data_word;

    synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (uart_rx_i),
        .q_o   (rx_sync)
    );

    // Delayed copy of the synchronised line for 1 -> 0 edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rx_d <= 1'b1;
        else       rx_d <= rx_sync;
    end

    assign fall      = rx_d & ~rx_sync;
    assign tick      = (baud_cnt == 16'd0);
    assign data_word = (ds_q == DS_8BIT) ? sr : {1'b0, sr[7:1]};

    // Next-state logic: bit timing, field sequencing and error accumulation.
    always_comb begin
        state_n     = state;
        baud_n      = tick ? baud_cnt : baud_cnt - 16'd1;
        bit_n       = bit_cnt;
        stop_left_n = stop_left;
        ferr_n      = ferr;
        perr_n      = perr;
        latch_cfg   = 1'b0;
        shift_en    = 1'b0;
        out_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_n     = START;
                    baud_n      = (eff_clk_div(cr_clk_div_i) >> 1) - 16'd1;
                    bit_n       = (cr_ds_i == DS_8BIT) ? 4'd8 : 4'd7;
                    stop_left_n = (cr_s_i == STOP_2BIT);
                    ferr_n      = 1'b0;
                    perr_n      = 1'b0;
                    latch_cfg   = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = rx_sync ? IDLE : DATA;
                    baud_n  = div_q - 16'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    bit_n    = bit_cnt - 4'd1;
                    baud_n   = div_q - 16'd1;
                    if (bit_cnt == 4'd1)
                        state_n = (par_q != PARITY_NONE) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_n  = (par_q == PARITY_EVEN) ? (^data_word ^ rx_sync)
                                                     : ~(^data_word ^ rx_sync);
                    baud_n  = div_q - 16'd1;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_sync) ferr_n = 1'b1;
                    if (stop_left) begin
                        stop_left_n = 1'b0;
                        baud_n      = div_q - 16'd1;
                    end else begin
                        state_n = IDLE;
                        out_en  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Control state and registered frame outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_cnt        <= '0;
            stop_left      <= 1'b0;
            ferr           <= 1'b0;
            perr           <= 1'b0;
            dr_o           <= '0;
            valid_o        <= 1'b0;
            frame_error_o  <= 1'b0;
            parity_error_o <= 1'b0;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            stop_left <= stop_left_n;
            ferr      <= ferr_n;
            perr      <= perr_n;
            valid_o   <= out_en;
            if (out_en) begin
                dr_o           <= data_word;
                frame_error_o  <= ferr_n;
                parity_error_o <= perr;
            end
        end
    end

    // Frame configuration snapshot and data shift register.
    always_ff @(posedge clk_i) begin
        if (latch_cfg) begin
            div_q <= eff_clk_div(cr_clk_div_i);
            ds_q  <= cr_ds_i;
            par_q <= (cr_p_i == 2'b11) ? PARITY_ODD : cr_p_i;
        end
        if (shift_en) sr <= {rx_sync, sr[7:1]};
    end

endmodule

// File: tb/tb_rx_frontend.sv
module tb_rx_frontend;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] cr_clk_div_i;
    logic        cr_ds_i;
    logic [1:0]  cr_p_i;
    logic        cr_s_i;
    logic        uart_rx_i;
    logic [7:0]  dr_o;
    logic        valid_o, frame_error_o, parity_error_o;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [7:0]  d;
        logic        fe;
        logic        pe;
        int unsigned c;
    } rec_t;

    rec_t got_q[$];

    rx_frontend #(.SYNC_STAGES(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .cr_clk_div_i   (cr_clk_div_i),
        .cr_ds_i        (cr_ds_i),
        .cr_p_i         (cr_p_i),
        .cr_s_i         (cr_s_i),
        .uart_rx_i      (uart_rx_i),
        .dr_o           (dr_o),
        .valid_o        (valid_o),
        .frame_error_o  (frame_error_o),
        .parity_error_o (parity_error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every output pulse, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (valid_o) got_q.push_back('{dr_o, frame_error_o, parity_error_o, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        uart_rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    // Drive one frame bit by bit; sets config just before the start bit.
    task automatic send_frame(input logic [7:0] data, input bit ds8, input logic [1:0] par,
                              input bit s2, input int div, input bit flip_par,
                              input logic [1:0] stop_vals);
        int nb;
        logic p;
        cr_clk_div_i = 16'(div);
        cr_ds_i      = ds8;
        cr_p_i       = par;
        cr_s_i       = s2;
        nb = ds8 ? 8 : 7;
        hold(1'b0, div);
        for (int i = 0; i < nb; i++) hold(data[i], div);
        if (par != 2'b00) begin
            p = 1'b0;
            for (int i = 0; i < nb; i++) p = p ^ data[i];
            if (par != 2'b01) p = ~p;          // odd parity: total ones odd
            hold(p ^ flip_par, div);
        end
        hold(stop_vals[0], div);
        if (s2) hold(stop_vals[1], div);
        uart_rx_i = 1'b1;
    endtask

    // Pop one pulse (bounded wait) and compare with the frame-level expectation.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe, input logic pe);
        rec_t r;
        int budget = 400;
        while (got_q.size() == 0 && budget > 0) begin
            @(negedge clk_i);
            budget--;
        end
        check({tag, "_present"}, got_q.size() != 0, 1);
        if (got_q.size() != 0) begin
            r = got_q.pop_front();
            check({tag, "_data"}, r.d, d);
            check({tag, "_ferr"}, r.fe, fe);
            check({tag, "_perr"}, r.pe, pe);
        end
    endtask

    initial begin
        int unsigned t0;
        rec_t r;
        logic [7:0] d;
        bit ds8, s2, flip;
        logic [1:0] par, sv;
        int div;
        logic exp_pe, exp_fe, ones;

        rst_i = 1'b1;
        uart_rx_i = 1'b1;
        cr_clk_div_i = 16'd16;
        cr_ds_i = 1'b1;
        cr_p_i = 2'b00;
        cr_s_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_dr", dr_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_ferr", frame_error_o, 0);
        check("rst_perr", parity_error_o, 0);
        rst_i = 1'b0;
        hold(1'b1, 10);

        // 8N1 div 16, 0xA5, with latency measured from the line edge.
        t0 = cyc;
        send_frame(8'hA5, 1, 2'b00, 0, 16, 0, 2'b11);
        hold(1'b1, 4);
        check("a5_count", got_q.size(), 1);
        if (got_q.size() != 0) begin
            r = got_q[0];
            check("a5_latency_ok", (r.c - t0 >= 152) && (r.c - t0 <= 158), 1);
        end
        expect_frame("a5", 8'hA5, 0, 0);
        hold(1'b1, 30);
        check("a5_hold", dr_o, 8'hA5);

        // 7E1 div 8, correct and wrong parity.
        send_frame(8'h55, 0, 2'b01, 0, 8, 0, 2'b11);
        hold(1'b1, 16);
        expect_frame("7e1_ok", 8'h55, 0, 0);
        send_frame(8'h55, 0, 2'b01, 0, 8, 1, 2'b11);
        hold(1'b1, 16);
        expect_frame("7e1_bad", 8'h55, 0, 1);

        // 8O2 div 10, second stop bit low.
        send_frame(8'h3C, 1, 2'b10, 1, 10, 0, 2'b01);
        hold(1'b1, 20);
        expect_frame("8o2_stop", 8'h3C, 1, 0);

        // Glitch shorter than half a bit.
        cr_clk_div_i = 16'd16; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
        hold(1'b0, 3);
        hold(1'b1, 60);
        check("glitch_none", got_q.size(), 0);

        // Break: 30 bit times low gives exactly one frame.
        hold(1'b0, 30 * 16);
        check("break_count", got_q.size(), 1);
        expect_frame("break", 8'h00, 1, 0);
        hold(1'b1, 40);
        check("break_quiet", got_q.size(), 0);

        // Reset mid-DATA, then a clean frame.
        hold(1'b0, 16);
        hold(1'b1, 40);
        rst_i = 1'b1;
        hold(1'b1, 5);
        check("rst_mid_valid", valid_o, 0);
        rst_i = 1'b0;
        hold(1'b1, 200);
        check("rst_mid_none", got_q.size(), 0);
        send_frame(8'h81, 1, 2'b00, 0, 16, 0, 2'b11);
        hold(1'b1, 20);
        expect_frame("after_rst", 8'h81, 0, 0);

        // Back-to-back frames, no idle gap.
        send_frame(8'h12, 1, 2'b00, 0, 16, 0, 2'b11);
        send_frame(8'h34, 1, 2'b00, 0, 16, 0, 2'b11);
        hold(1'b1, 20);
        check("b2b_count", got_q.size(), 2);
        expect_frame("b2b_0", 8'h12, 0, 0);
        expect_frame("b2b_1", 8'h34, 0, 0);

        // Randomised frames against the frame-level model.
        for (int k = 0; k < 16; k++) begin
            d    = 8'($urandom);
            ds8  = 1'($urandom);
            par  = 2'($urandom_range(0, 3));
            s2   = 1'($urandom);
            div  = $urandom_range(6, 24);
            flip = ($urandom_range(0, 3) == 0);
            sv   = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
            ones = 1'b0;
            for (int i = 0; i < (ds8 ? 8 : 7); i++) ones = ones ^ d[i];
            // Sent parity bit satisfies the rule unless flipped.
            exp_pe = (par != 2'b00) ? flip : 1'b0;
            exp_fe = s2 ? ~(sv[0] & sv[1]) : ~sv[0];
            send_frame(d, ds8, par, s2, div, flip, sv);
            hold(1'b1, 2 * div);
            expect_frame($sformatf("rnd%0d", k), ds8 ? d : {1'b0, d[6:0]}, exp_fe, exp_pe);
            check($sformatf("rnd%0d_extra", k), got_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
